axi_ram_rd: RTL and testbench

AXI_RAM_RD -- requirements
Module: axi_ram_rd

---
 rtl/axi_pkg.sv | 21 ++
 rtl/stream_fifo.sv | 54 +++++
 rtl/axi_ram_rd.sv | 157 +++++++++++++++
 tb/tb_axi_ram_rd.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types for the AXI RAM read bridge: burst encodings, response codes,
// controller states and the depth of the read-return buffer.
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_t;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } rd_state_t;

   localparam int unsigned RET_FIFO_DEPTH = 4;

endpackage

// File: rtl/stream_fifo.sv
// Small register-based FIFO with valid/ready on both sides; head entry is
// presented directly from storage so outputs are registered.
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Pointers wrap naturally, so DEPTH must be a power of two.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_ram_rd.sv
// AXI4 read-channel front end for a single-port RAM with registered read data.
// state | meaning
// IDLE  | ar_ready high, waiting for an address
// BURST | issuing word reads and returning beats until the r_last handshake
module axi_ram_rd
   import axi_pkg::*;
#(
   parameter  int ID_WIDTH    = 4,
   parameter  int ADDR_WIDTH  = 16,
   parameter  int BATCH_WIDTH = 4,
   parameter  int BYTE_WIDTH  = 8,
   localparam int AXI_AW      = ADDR_WIDTH + $clog2(BATCH_WIDTH),
   localparam int DW          = BYTE_WIDTH * BATCH_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   ar_id,
   input  logic [AXI_AW-1:0]     ar_addr,
   input  logic [7:0]            ar_len,
   input  logic [2:0]            ar_size,
   input  logic [1:0]            ar_burst,
   input  logic                  ar_valid,
   output logic                  ar_ready,
   output logic [ID_WIDTH-1:0]   r_id,
   output logic [DW-1:0]         r_data,
   output logic [1:0]            r_resp,
   output logic                  r_last,
   output logic                  r_valid,
   input  logic                  r_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic                  ram_write_en_o,
   input  logic [DW-1:0]         ram_data_i
);

   localparam int SHIFT = $clog2(BATCH_WIDTH);
   localparam int FW    = DW + 3;
   localparam int CW    = $clog2(RET_FIFO_DEPTH + 1);

   function automatic logic [AXI_AW-1:0] next_addr(input logic [AXI_AW-1:0] addr,
                                                   input logic [2:0]        size,
                                                   input logic [7:0]        len,
                                                   input logic [1:0]        burst);
      logic [AXI_AW-1:0] incr;
      logic [AXI_AW-1:0] mask;
      incr = addr + (AXI_AW'(1) << size);
      mask = ((AXI_AW'(len) + AXI_AW'(1)) << size) - AXI_AW'(1);
      if (burst == FIXED)     next_addr = addr;
      else if (burst == WRAP) next_addr = (addr & ~mask) | (incr & mask);
      else                    next_addr = incr;
   endfunction

   rd_state_t         state;
   logic [ID_WIDTH-1:0] id_q;
   logic [AXI_AW-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        remain_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   logic              err_q;
   logic              s1_v, s1_last, s2_v, s2_last;
   logic              ar_bad;
   logic              issue;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     fill;
   logic              fifo_in_ready;
   logic              fifo_push;
   logic [FW-1:0]     fifo_in;
   logic [FW-1:0]     fifo_out;

   assign ar_bad = (ar_size > 3'(SHIFT)) || (ar_burst == 2'd3) ||
                   ((ar_burst == WRAP) && !(ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

   // Beats already issued but not yet in the FIFO still need a slot reserved.
   assign fill  = fifo_count + CW'(s1_v) + CW'(s2_v);
   assign issue = (state == BURST) && (remain_q != 8'd0) && (fill < CW'(RET_FIFO_DEPTH));

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ar_ready   <= 1'b1;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         remain_q   <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         err_q      <= 1'b0;
         s1_v       <= 1'b0;
         s1_last    <= 1'b0;
         s2_v       <= 1'b0;
         s2_last    <= 1'b0;
         ram_addr_o <= '0;
      end else begin
         s1_v    <= 1'b0;
         s2_v    <= s1_v;
         s2_last <= s1_last;
         case (state)
            IDLE: begin
               if (ar_valid && ar_ready) begin
                  state    <= BURST;
                  ar_ready <= 1'b0;
                  id_q     <= ar_id;
                  len_q    <= ar_len;
                  size_q   <= ar_size;
                  burst_q  <= ar_burst;
                  err_q    <= ar_bad;
                  addr_q   <= next_addr(ar_addr, ar_size, ar_len, ar_burst);
                  remain_q <= ar_len;
                  s1_v     <= 1'b1;
                  s1_last  <= (ar_len == 8'd0);
                  if (!ar_bad) ram_addr_o <= ar_addr[AXI_AW-1:SHIFT];
               end
            end
            BURST: begin
               if (issue) begin
                  addr_q   <= next_addr(addr_q, size_q, len_q, burst_q);
                  remain_q <= remain_q - 8'd1;
                  s1_v     <= 1'b1;
                  s1_last  <= (remain_q == 8'd1);
                  if (!err_q) ram_addr_o <= addr_q[AXI_AW-1:SHIFT];
               end
               if (r_valid && r_ready && r_last) begin
                  state    <= IDLE;
                  ar_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Error bursts still flow through the pipeline so beat timing is unchanged.
   assign fifo_in   = {(err_q ? '0 : ram_data_i), (err_q ? SLVERR : OKAY), s2_last};
   assign fifo_push = s2_v && fifo_in_ready;

   stream_fifo #(
      .DEPTH (RET_FIFO_DEPTH),
      .WIDTH (FW)
   ) u_ret_fifo (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .in_data   (fifo_in),
      .in_valid  (fifo_push),
      .in_ready  (fifo_in_ready),
      .out_data  (fifo_out),
      .out_valid (r_valid),
      .out_ready (r_ready),
      .count     (fifo_count)
   );

   assign r_data         = fifo_out[FW-1:3];
   assign r_resp         = fifo_out[2:1];
   assign r_last         = fifo_out[0];
   assign r_id           = id_q;
   assign ram_write_en_o = 1'b0;

endmodule

// File: tb/tb_axi_ram_rd.sv
// Directed bench for axi_ram_rd with a registered RAM model and a beat scoreboard.
module tb_axi_ram_rd;
   import axi_pkg::*;

   localparam int IDW = 4;
   localparam int AW  = 16;
   localparam int AXW = 18;
   localparam int DW  = 32;

   logic           clk_i = 1'b0;
   logic           rst_n = 1'b0;
   logic [IDW-1:0] ar_id;
   logic [AXW-1:0] ar_addr;
   logic [7:0]     ar_len;
   logic [2:0]     ar_size;
   logic [1:0]     ar_burst;
   logic           ar_valid;
   logic           ar_ready;
   logic [IDW-1:0] r_id;
   logic [DW-1:0]  r_data;
   logic [1:0]     r_resp;
   logic           r_last;
   logic           r_valid;
   logic           r_ready;
   logic [AW-1:0]  ram_addr_o;
   logic           ram_write_en_o;
   logic [DW-1:0]  ram_data_i = '0;

   axi_ram_rd dut (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .ar_id          (ar_id),
      .ar_addr        (ar_addr),
      .ar_len         (ar_len),
      .ar_size        (ar_size),
      .ar_burst       (ar_burst),
      .ar_valid       (ar_valid),
      .ar_ready       (ar_ready),
      .r_id           (r_id),
      .r_data         (r_data),
      .r_resp         (r_resp),
      .r_last         (r_last),
      .r_valid        (r_valid),
      .r_ready        (r_ready),
      .ram_addr_o     (ram_addr_o),
      .ram_write_en_o (ram_write_en_o),
      .ram_data_i     (ram_data_i)
   );

   always #5 clk_i = ~clk_i;

   // RAM word content encodes its own address so the issued address is visible in r_data.
   always @(posedge clk_i) ram_data_i <= {16'hC0DE, ram_addr_o};

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   beat_t          sb[$];
   int             n_tests = 0;
   int             n_fail  = 0;
   logic [IDW-1:0] cur_id  = '0;
   int             first_c, last_c;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ok(input logic [AW-1:0] word, input logic last);
      sb.push_back('{data: {16'hC0DE, word}, resp: OKAY, last: last});
   endtask

   task automatic push_err(input int n);
      for (int i = 0; i < n; i++) sb.push_back('{data: '0, resp: SLVERR, last: (i == n-1)});
   endtask

   task automatic ar_send(input logic [IDW-1:0] id, input logic [AXW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
      ar_valid = 1'b1;
      cur_id = id;
      check("ar_ready_idle", ar_ready, 1);
      @(posedge clk_i);
      @(negedge clk_i);
      ar_valid = 1'b0;
      check("ar_ready_busy", ar_ready, 0);
   endtask

   // c counts falling edges after the AR handshake edge; c==2 is right after edge k+2.
   task automatic drain(input logic [3:0] pat, input int stop_after, input bit hold_addr,
                        output int f_c, output int l_c);
      int            c = 0;
      int            hs = 0;
      bit            done = 0;
      logic [AW-1:0] addr0;
      addr0 = ram_addr_o;
      f_c = -1;
      l_c = -1;
      while (!done && c < 200) begin
         r_ready = pat[c % 4];
         check("ar_ready_in_burst", ar_ready, 0);
         if (r_valid) begin
            if (f_c < 0) f_c = c;
            if (sb.size() == 0) begin
               check("r_valid_extra", r_valid, 0);
               done = 1;
            end else begin
               check("r_data", r_data, sb[0].data);
               check("r_resp", r_resp, sb[0].resp);
               check("r_last", r_last, sb[0].last);
               check("r_id", r_id, cur_id);
               if (r_ready) begin
                  hs++;
                  if (sb[0].last) begin
                     done = 1;
                     l_c  = c;
                  end
                  void'(sb.pop_front());
                  if (stop_after != 0 && hs == stop_after) done = 1;
               end
            end
         end
         if (hold_addr) check("ram_addr_hold", ram_addr_o, addr0);
         @(negedge clk_i);
         c++;
      end
      check("burst_done", done, 1);
      r_ready = 1'b0;
   endtask

   task automatic end_burst();
      check("ar_ready_after", ar_ready, 1);
      check("r_valid_after", r_valid, 0);
      check("ram_we", ram_write_en_o, 0);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
      ar_valid = 1'b0; r_ready = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_ar_ready", ar_ready, 1);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_last", r_last, 0);
      check("rst_r_resp", r_resp, 0);
      check("rst_r_id", r_id, 0);
      check("rst_r_data", r_data, 0);
      check("rst_ram_addr", ram_addr_o, 0);
      check("rst_ram_we", ram_write_en_o, 0);
      rst_n = 1'b1;
      @(negedge clk_i);

      // INCR 0x10 len 3: words 4..7, latency and one beat per cycle
      for (int i = 0; i < 4; i++) push_ok(16'(4 + i), i == 3);
      ar_send(4'h3, 18'h00010, 8'd3, 3'd2, INCR);
      drain(4'b1111, 0, 0, first_c, last_c);
      check("incr_first_latency", first_c, 2);
      check("incr_throughput", last_c - first_c, 3);
      end_burst();

      // WRAP 0x38 len 3
      push_ok(16'hE, 0); push_ok(16'hF, 0); push_ok(16'hC, 0); push_ok(16'hD, 1);
      ar_send(4'h5, 18'h00038, 8'd3, 3'd2, WRAP);
      drain(4'b1111, 0, 0, first_c, last_c);
      end_burst();

      // backpressure 1,0,0,1
      for (int i = 0; i < 8; i++) push_ok(16'(16'h40 + i), i == 7);
      ar_send(4'h7, 18'h00100, 8'd7, 3'd2, INCR);
      drain(4'b1001, 0, 0, first_c, last_c);
      end_burst();

      // oversize beat
      push_err(2);
      ar_send(4'h9, 18'h00040, 8'd1, 3'd3, INCR);
      drain(4'b1111, 0, 1, first_c, last_c);
      end_burst();

      // reserved burst type
      push_err(2);
      ar_send(4'hA, 18'h00080, 8'd1, 3'd2, 2'd3);
      drain(4'b1011, 0, 1, first_c, last_c);
      end_burst();

      // WRAP with illegal length
      push_err(3);
      ar_send(4'hB, 18'h00080, 8'd2, 3'd2, WRAP);
      drain(4'b1111, 0, 1, first_c, last_c);
      end_burst();

      // INCR from the top word wraps to word 0
      push_ok(16'hFFFF, 0); push_ok(16'h0000, 1);
      ar_send(4'h1, 18'h3FFFC, 8'd1, 3'd2, INCR);
      drain(4'b1111, 0, 0, first_c, last_c);
      end_burst();

      // FIXED len 2
      push_ok(16'h8, 0); push_ok(16'h8, 0); push_ok(16'h8, 1);
      ar_send(4'h2, 18'h00020, 8'd2, 3'd2, FIXED);
      drain(4'b1111, 0, 0, first_c, last_c);
      end_burst();

      // byte-sized INCR from 0x7: bytes 7..C
      push_ok(16'h1, 0); push_ok(16'h2, 0); push_ok(16'h2, 0);
      push_ok(16'h2, 0); push_ok(16'h2, 0); push_ok(16'h3, 1);
      ar_send(4'h4, 18'h00007, 8'd5, 3'd0, INCR);
      drain(4'b1111, 0, 0, first_c, last_c);
      end_burst();

      // reset after the second beat of an 8-beat burst
      for (int i = 0; i < 8; i++) push_ok(16'(16'h80 + i), i == 7);
      ar_send(4'h6, 18'h00200, 8'd7, 3'd2, INCR);
      drain(4'b1111, 2, 0, first_c, last_c);
      rst_n = 1'b0;
      #1;
      check("midrst_r_valid", r_valid, 0);
      check("midrst_ar_ready", ar_ready, 1);
      check("midrst_ram_addr", ram_addr_o, 0);
      sb.delete();
      @(negedge clk_i);
      rst_n = 1'b1;
      @(negedge clk_i);
      check("post_rst_r_valid", r_valid, 0);
      for (int i = 0; i < 4; i++) push_ok(16'(16'hC + i), i == 3);
      ar_send(4'hC, 18'h00030, 8'd3, 3'd2, INCR);
      drain(4'b1111, 0, 0, first_c, last_c);
      check("post_rst_latency", first_c, 2);
      end_burst();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
